// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer pattern decoder.
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ON      = 2'd1,
        OFF     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [1:0] ERR_SHORT_ON  = 2'd0;
    localparam logic [1:0] ERR_LONG_ON   = 2'd1;
    localparam logic [1:0] ERR_SHORT_OFF = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

    localparam int DUR_W = 8;

    // Tick counter step that sticks at all-ones instead of wrapping.
    function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] d);
        return (d == {DUR_W{1'b1}}) ? d : d + 1'b1;
    endfunction

endpackage

// File: rtl/buzz_pattern_decoder_sync_edge.sv
// Two-flop synchronizer for the beep line plus registered rise/fall detection.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;
    logic [1:0] r_warm;

    // Edges stay masked until the pipeline holds real samples, so a line
    // already high when reset releases is not mistaken for a rise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_warm  <= 2'd0;
        end else begin
            r_meta  <= i_d;
            r_sync  <= r_meta;
            r_level <= r_sync;
            r_warm  <= (r_warm == 2'd3) ? r_warm : r_warm + 2'd1;
            r_rise  <= (r_warm == 2'd3) &&  r_sync && !r_level;
            r_fall  <= (r_warm == 2'd3) && !r_sync &&  r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/buzz_pattern_decoder.sv
// Times high/low intervals of a beep line in 1 ms ticks and reports the
// number of valid beeps per frame, or an error code for a malformed frame.
module buzz_pattern_decoder
    import buzz_pkg::*;
#(
    parameter int MIN_ON_MS  = 40,
    parameter int MAX_ON_MS  = 60,
    parameter int MIN_OFF_MS = 40,
    parameter int MAX_OFF_MS = 60,
    parameter int MAX_BEEPS  = 7,
    parameter int CW         = $clog2(MAX_BEEPS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pls_1k,
    input  logic          i_buzz,
    output logic          o_valid,
    output logic [CW-1:0] o_beep_cnt,
    output logic          o_err,
    output logic [1:0]    o_err_code,
    output logic          o_busy
);

    localparam int BW = CW + 1;
    localparam logic [DUR_W-1:0] L_MIN_ON    = DUR_W'(MIN_ON_MS);
    localparam logic [DUR_W-1:0] L_ON_LIMIT  = DUR_W'(MAX_ON_MS + 1);
    localparam logic [DUR_W-1:0] L_MIN_OFF   = DUR_W'(MIN_OFF_MS);
    localparam logic [DUR_W-1:0] L_OFF_LIMIT = DUR_W'(MAX_OFF_MS + 1);
    localparam logic [BW-1:0]    L_MAX_BEEPS = BW'(MAX_BEEPS);
    localparam logic [BW-1:0]    L_BEEP_SAT  = BW'(MAX_BEEPS + 1);

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_buzz),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    state_t           r_state,    w_state_nx;
    logic [DUR_W-1:0] r_dur,      w_dur_nx;
    logic [BW-1:0]    r_beeps,    w_beeps_nx;
    logic             r_valid,    w_valid_nx;
    logic             r_err,      w_err_nx;
    logic [CW-1:0]    r_beep_cnt, w_cnt_nx;
    logic [1:0]       r_err_code, w_code_nx;

    always_comb begin
        w_state_nx = r_state;
        w_beeps_nx = r_beeps;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_cnt_nx   = r_beep_cnt;
        w_code_nx  = r_err_code;
        w_dur_nx   = r_dur;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_beeps_nx = '0;
                    w_state_nx = ON;
                end
            end
            ON: begin
                if (w_fall) begin
                    if (r_dur < L_MIN_ON) begin
                        w_err_nx   = 1'b1;
                        w_code_nx  = ERR_SHORT_ON;
                        w_state_nx = RECOVER;
                    end else begin
                        w_beeps_nx = (r_beeps == L_BEEP_SAT) ? r_beeps : r_beeps + 1'b1;
                        w_state_nx = OFF;
                    end
                end else if (r_dur >= L_ON_LIMIT) begin
                    w_err_nx   = 1'b1;
                    w_code_nx  = ERR_LONG_ON;
                    w_state_nx = RECOVER;
                end
            end
            OFF: begin
                if (w_rise) begin
                    if (r_dur < L_MIN_OFF) begin
                        w_err_nx   = 1'b1;
                        w_code_nx  = ERR_SHORT_OFF;
                        w_state_nx = RECOVER;
                    end else begin
                        w_state_nx = ON;
                    end
                end else if (r_dur >= L_OFF_LIMIT) begin
                    w_state_nx = IDLE;
                    if (r_beeps <= L_MAX_BEEPS) begin
                        w_valid_nx = 1'b1;
                        w_cnt_nx   = r_beeps[CW-1:0];
                    end else begin
                        w_err_nx   = 1'b1;
                        w_code_nx  = ERR_OVERFLOW;
                    end
                end
            end
            RECOVER: begin
                if (!w_level && !w_rise && !w_fall && r_dur >= L_OFF_LIMIT)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase

        // An edge wins over a coincident tick; in RECOVER only low time counts.
        if (w_state_nx != r_state || w_rise || w_fall || (r_state == RECOVER && w_level))
            w_dur_nx = '0;
        else if (i_pls_1k)
            w_dur_nx = dur_inc(r_dur);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_dur      <= '0;
            r_beeps    <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_beep_cnt <= '0;
            r_err_code <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_dur      <= w_dur_nx;
            r_beeps    <= w_beeps_nx;
            r_valid    <= w_valid_nx;
            r_err      <= w_err_nx;
            r_beep_cnt <= w_cnt_nx;
            r_err_code <= w_code_nx;
        end
    end

    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_beep_cnt = r_beep_cnt;
    assign o_err_code = r_err_code;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: doc/buzz_pattern_decoder.md
# buzz_pattern_decoder

Receive-side counterpart of the buzzer pattern driver. Samples a 1-bit buzzer/beep line, times each high and low interval in 1 ms ticks, and counts valid beeps in a frame. When the line stays quiet long enough to end the frame, it reports the beep count. Malformed frames are flagged with an error code. Used for loopback self-test of the alarm path and for decoding beep-coded status from a neighbouring board.

## Interface
- MIN_ON_MS, default 40: shortest accepted beep, in ticks.
- MAX_ON_MS, default 60: longest accepted beep, in ticks.
- MIN_OFF_MS, default 40: shortest accepted gap between beeps.
- MAX_OFF_MS, default 60: longest intra-frame gap; reaching MAX_OFF_MS+1 ends the frame.
- MAX_BEEPS, default 7: largest reportable count. CW = $clog2(MAX_BEEPS+1).
- i_clk, input, 1: system clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_pls_1k, input, 1: one-cycle 1 kHz tick.
- i_buzz, input, 1: asynchronous beep line. High = beep.
- o_valid, output, 1: one-cycle pulse, frame decoded.
- o_beep_cnt, output, CW: beep count. Held from o_valid until the next o_valid.
- o_err, output, 1: one-cycle pulse, frame rejected.
- o_err_code, output, 2: error code, held until the next o_err. Codes: 0 = short beep, 1 = long beep, 2 = short gap, 3 = overflow.
- o_busy, output, 1: high whenever state is not IDLE.

## Operation
- Input path: i_buzz goes through a 2-flop synchronizer, then a registered edge detector, producing rise and fall pulses.
- Duration counter dur: 8 bits, saturates at 255. Cleared on every state entry. Increments on i_pls_1k.
- Beep counter beeps: CW+1 bits wide.
- Priority: an edge overrides a simultaneous tick. The counter clears and the tick is lost.
- IDLE:
  - On rise: beeps←0, go to ON.
- ON:
  - On fall with dur < MIN_ON_MS: error 0, go to RECOVER.
  - On fall otherwise: beeps←beeps+1, go to OFF.
  - If dur reaches MAX_ON_MS+1 while the line is high: error 1, go to RECOVER.
- OFF:
  - On rise with dur < MIN_OFF_MS: error 2, go to RECOVER.
  - On rise otherwise: go to ON.
  - If dur reaches MAX_OFF_MS+1: end of frame.
    - beeps ≤ MAX_BEEPS: o_valid, o_beep_cnt←beeps, go to IDLE.
    - Otherwise: error 3, go to IDLE.
- RECOVER:
  - Any edge clears dur.
  - Leave for IDLE only after the synchronized line has been low for MAX_OFF_MS+1 consecutive ticks.
- Overflow is evaluated only at frame end. beeps saturates at MAX_BEEPS+1.
- A rise in IDLE always starts a frame. There is no minimum idle time.

## Timing
- Reset values:
  - State: IDLE.
  - o_valid=0, o_err=0, o_busy=0.
  - o_beep_cnt=0, o_err_code=0.
  - dur=0, beeps=0, synchronizer flops=0.
- i_buzz edge to internal rise/fall pulse: 3 cycles (2 sync + 1 edge register).
- Decision to output: o_valid and o_err are registered. They assert in the cycle after the state register takes the decision. o_beep_cnt and o_err_code update in that same cycle.
- o_valid and o_err are never high in the same cycle.
- Frame-end latency: o_valid rises MAX_OFF_MS+1 ticks after the last falling edge (+4 cycles). For default parameters, ≈61 ms.
- Tolerance window is ±1 tick because ticks and edges are asynchronous.
  - A 50-tick beep measures 49–50.
  - The driver's ~49-tick beeps and 50-tick gaps fall inside the defaults.
- i_rst mid-frame returns to IDLE in one cycle. No output pulse is produced. A line held high at release starts a frame only on a new rise.

## Structure
- Shared package buzz_pkg holds:
  - State enum: IDLE, ON, OFF, RECOVER.
  - Error code constants: ERR_SHORT_ON, ERR_LONG_ON, ERR_SHORT_OFF, ERR_OVERFLOW.
  - DUR_W = 8.
- One sub-module, sync_edge. It contains the 2-flop synchronizer plus the rise/fall detector, with i_clk, i_rst, i_d, o_level, o_rise, o_fall.
- The FSM, counters and output registers live in the top module.

## Test plan
- Three beeps at 49 ms on / 50 ms off, then line low → one o_valid with o_beep_cnt=3, ≈61 ms after the last fall; no o_err.
- Single 50 ms beep → o_valid, o_beep_cnt=1. A following frame of 2 beeps → o_valid, o_beep_cnt=2.
- 10 ms glitch in IDLE → o_err with code 0. A valid 3-beep frame starting 70 ms later decodes as 3.
- Line held high for 200 ms → o_err with code 1 at ≈61 ms. No further pulses until the line has been low for 61 ms.
- Beeps with a 20 ms gap → o_err with code 2.
- Eight valid beeps → o_err with code 3 at frame end.
- i_rst asserted during the 2nd beep of a 3-beep frame → outputs return to 0 and no pulses occur. The next clean frame decodes normally.
